behav_counter_block: RTL and testbench

Module `behav_counter` is an 8-bit up/down counter with a configurable step, a clock prescaler and a masked parallel load. It also drives two wrap indicators: a combinational "about to wrap" flag and a registered, stretchable carry/borrow pulse. It is a general-purpose event/position counter used as a leaf block in datapath control logic.

---
 rtl/behav_counter_block.sv | 72 +++++++
 tb/tb_behav_counter_block.sv | 138 +++++++++++++
 2 files changed

// File: rtl/behav_counter_block.sv
// 8-bit up/down counter with programmable step, prescaler, masked parallel
// load, a combinational wrap-pending flag and a stretchable carry/borrow pulse.
module behav_counter_block #(
    parameter int DATA_WIDTH = 1,
    parameter int KEEP_WIDTH = 1,
    parameter int HDR_WIDTH  = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] d,
    input  logic       load,
    input  logic [7:0] load_b,
    input  logic       up_down,
    output logic [7:0] qd,
    output logic       qd_b,
    output logic       qd_c
);

    localparam logic [7:0] STEP     = 8'(DATA_WIDTH);
    localparam logic [7:0] KEEP     = 8'(KEEP_WIDTH);
    localparam logic [7:0] PRE_LAST = 8'(HDR_WIDTH - 1);

    logic [7:0] r_cnt;
    logic [7:0] r_pre;
    logic [7:0] r_str;

    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic       w_tick;
    logic       w_wrap_next;
    logic       w_wrap;
    logic [7:0] w_loaded;

    // Bit 8 of the sum/difference is the carry/borrow of the next step.
    assign w_sum       = {1'b0, r_cnt} + {1'b0, STEP};
    assign w_diff      = {1'b0, r_cnt} - {1'b0, STEP};
    assign w_tick      = (r_pre == PRE_LAST);
    assign w_wrap_next = up_down ? w_sum[8] : w_diff[8];
    assign w_wrap      = !load && w_tick && w_wrap_next;
    assign w_loaded    = (d & load_b) | (r_cnt & ~load_b);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_cnt <= 8'h00;
            r_pre <= 8'h00;
        end else if (load) begin
            r_cnt <= w_loaded;
            r_pre <= 8'h00;
        end else if (w_tick) begin
            r_cnt <= up_down ? w_sum[7:0] : w_diff[7:0];
            r_pre <= 8'h00;
        end else begin
            r_pre <= r_pre + 8'h01;
        end
    end

    // A wrap while the pulse is still active reloads the stretch count.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_str <= 8'h00;
        end else if (w_wrap) begin
            r_str <= KEEP;
        end else if (r_str != 8'h00) begin
            r_str <= r_str - 8'h01;
        end
    end

    assign qd   = r_cnt;
    assign qd_b = w_wrap_next;
    assign qd_c = (r_str != 8'h00);

endmodule

// File: tb/tb_behav_counter_block.sv
// Directed bench: default-parameter instance plus a step=3 / keep=2 / prescale=4 instance.
module tb_behav_counter_block;

    logic       clk;
    logic       clear1, clear2;
    logic [7:0] d1, d2, load_b1, load_b2;
    logic       load1, load2, up1, up2;
    logic [7:0] qd1, qd2;
    logic       qd_b1, qd_b2, qd_c1, qd_c2;

    int checks = 0;
    int errors = 0;

    behav_counter_block u_dut1 (
        .clk(clk), .clear(clear1), .d(d1), .load(load1), .load_b(load_b1),
        .up_down(up1), .qd(qd1), .qd_b(qd_b1), .qd_c(qd_c1)
    );

    behav_counter_block #(.DATA_WIDTH(3), .KEEP_WIDTH(2), .HDR_WIDTH(4)) u_dut2 (
        .clk(clk), .clear(clear2), .d(d2), .load(load2), .load_b(load_b2),
        .up_down(up2), .qd(qd2), .qd_b(qd_b2), .qd_c(qd_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [7:0] q, input logic b, input logic c);
        check({tag, ".qd"}, qd1, q);
        check({tag, ".qd_b"}, {7'd0, qd_b1}, {7'd0, b});
        check({tag, ".qd_c"}, {7'd0, qd_c1}, {7'd0, c});
    endtask

    task automatic chk2(input string tag, input logic [7:0] q, input logic b, input logic c);
        check({tag, ".qd"}, qd2, q);
        check({tag, ".qd_b"}, {7'd0, qd_b2}, {7'd0, b});
        check({tag, ".qd_c"}, {7'd0, qd_c2}, {7'd0, c});
    endtask

    initial begin
        clear1 = 1'b0; clear2 = 1'b0;
        d1 = 8'h00; d2 = 8'h00; load_b1 = 8'h00; load_b2 = 8'h00;
        load1 = 1'b0; load2 = 1'b0; up1 = 1'b1; up2 = 1'b1;

        // Reset held across clock edges
        step(); step(); step();
        chk1("rst_up", 8'h00, 1'b0, 1'b0);
        up1 = 1'b0; #1;
        chk1("rst_dn", 8'h00, 1'b1, 1'b0);
        up1 = 1'b1;

        // Release: count every cycle
        clear1 = 1'b1;
        step(); chk1("cnt1", 8'h01, 1'b0, 1'b0);
        step(); chk1("cnt2", 8'h02, 1'b0, 1'b0);
        step(); chk1("cnt3", 8'h03, 1'b0, 1'b0);

        // Up-wrap
        load1 = 1'b1; d1 = 8'hFE; load_b1 = 8'hFF;
        step(); chk1("ld_fe", 8'hFE, 1'b0, 1'b0);
        load1 = 1'b0;
        step(); chk1("up_ff", 8'hFF, 1'b1, 1'b0);
        step(); chk1("up_wrap", 8'h00, 1'b0, 1'b1);
        step(); chk1("up_after", 8'h01, 1'b0, 1'b0);

        // Down-borrow
        load1 = 1'b1; d1 = 8'h01; up1 = 1'b0;
        step(); chk1("ld_01", 8'h01, 1'b0, 1'b0);
        load1 = 1'b0;
        step(); chk1("dn_00", 8'h00, 1'b1, 1'b0);
        step(); chk1("dn_wrap", 8'hFF, 1'b0, 1'b1);
        step(); chk1("dn_after", 8'hFE, 1'b0, 1'b0);

        // Masked load
        up1 = 1'b1; load1 = 1'b1; d1 = 8'hA5; load_b1 = 8'hFF;
        step(); chk1("ld_a5", 8'hA5, 1'b0, 1'b0);
        d1 = 8'h0F; load_b1 = 8'hF0;
        step(); chk1("mask_ld", 8'h05, 1'b0, 1'b0);
        d1 = 8'hFF; load_b1 = 8'h00;
        step(); chk1("mask_zero", 8'h05, 1'b0, 1'b0);

        // Load and a wrapping tick in the same cycle: load wins, no pulse
        load_b1 = 8'hFF;
        step(); chk1("ld_ff", 8'hFF, 1'b1, 1'b0);
        d1 = 8'h00; load_b1 = 8'h00;
        step(); chk1("ld_vs_tick", 8'hFF, 1'b1, 1'b0);
        load1 = 1'b0;

        // Async reset in the middle of a pulse
        step(); chk1("pre_rst", 8'h00, 1'b0, 1'b1);
        clear1 = 1'b0; #2;
        chk1("async_rst", 8'h00, 1'b0, 1'b0);

        // Instance 2: step 3, prescale 4, pulse length 2
        clear2 = 1'b1; load2 = 1'b1; d2 = 8'hFD; load_b2 = 8'hFF;
        step(); chk2("p_ld_fd", 8'hFD, 1'b1, 1'b0);
        load2 = 1'b0;
        step(); chk2("p_hold1", 8'hFD, 1'b1, 1'b0);
        step(); chk2("p_hold2", 8'hFD, 1'b1, 1'b0);
        step(); chk2("p_hold3", 8'hFD, 1'b1, 1'b0);
        step(); chk2("p_wrap", 8'h00, 1'b0, 1'b1);
        step(); chk2("p_pulse2", 8'h00, 1'b0, 1'b1);
        step(); chk2("p_pulse_end", 8'h00, 1'b0, 1'b0);
        step(); chk2("p_hold4", 8'h00, 1'b0, 1'b0);
        step(); chk2("p_tick03", 8'h03, 1'b0, 1'b0);
        step(); step();
        chk2("p_mid", 8'h03, 1'b0, 1'b0);
        load2 = 1'b1; d2 = 8'h10;
        step(); chk2("p_ld_10", 8'h10, 1'b0, 1'b0);
        load2 = 1'b0;
        step(); chk2("p_rs1", 8'h10, 1'b0, 1'b0);
        step(); chk2("p_rs2", 8'h10, 1'b0, 1'b0);
        step(); chk2("p_rs3", 8'h10, 1'b0, 1'b0);
        step(); chk2("p_tick13", 8'h13, 1'b0, 1'b0);

        // Down direction with prescaler: 0x13 -> 0x10 after 4 more cycles
        up2 = 1'b0;
        step(); step(); step();
        chk2("p_dn_hold", 8'h13, 1'b0, 1'b0);
        step(); chk2("p_dn_tick", 8'h10, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
